// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the Gray sequence checker slice:
//   - default code width and wrap-counter width
//   - checker state encoding (state_t)
//   - error cause encoding reported on err_code
// -----------------------------------------------------------------------------
package gray_pkg;

    localparam int GRAY_WIDTH_DEF = 3;
    localparam int WRAP_CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_WAIT_FIRST = 2'd0,
        ST_TRACK      = 2'd1,
        ST_FAULT      = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_STEP = 2'd1;
    localparam logic [1:0] ERR_OVF  = 2'd2;

endpackage

// File: rtl/gray_seq_checker_gray2bin.sv
// -----------------------------------------------------------------------------
// gray2bin
// Purely combinational Gray-to-binary decoder.
//   gray : Gray-coded input, WIDTH bits
//   bin  : binary equivalent, WIDTH bits
// Each binary bit is the XOR of all Gray bits at or above its position, which
// is the unrolled form of b[i] = b[i+1] ^ g[i] with b[MSB] = g[MSB].
// -----------------------------------------------------------------------------
module gray2bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_seq_checker.sv
// -----------------------------------------------------------------------------
// gray_seq_checker
// Receiving-end monitor for a Gray counter: decodes each valid sample,
// checks that it is a legal single step from the previous one, counts
// wrap-arounds and cross-checks the counter's overflow line. Protocol
// violations latch a sticky fault until clear or reset.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high reset
//   valid      : sample strobe for gray_in / ovf_in
//   gray_in    : Gray code from the counter (WIDTH bits)
//   ovf_in     : counter overflow output, sampled with gray_in
//   clear      : synchronous return to WAIT_FIRST; clears error and wrap count
//   binary     : registered decode of the last valid sample
//   locked     : high while tracking
//   wrap       : one-cycle pulse on a legal wrap step
//   error      : sticky violation flag
//   err_code   : 0 none, 1 illegal step, 2 overflow mismatch
//   wrap_count : saturating count of upward wraps
//
// Build option:
//   GRAY_DOWN_STEP_EN : when defined, a -1 step (including 0 -> max) is
//                       legal; a down-wrap pulses wrap but is not counted,
//                       and overflow is expected high when a down step
//                       lands on 0.
// -----------------------------------------------------------------------------
module gray_seq_checker
    import gray_pkg::*;
#(
    parameter int WIDTH      = GRAY_WIDTH_DEF,
    parameter int WRAP_CNT_W = WRAP_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic [WIDTH-1:0]      gray_in,
    input  logic                  ovf_in,
    input  logic                  clear,
    output logic [WIDTH-1:0]      binary,
    output logic                  locked,
    output logic                  wrap,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [WRAP_CNT_W-1:0] wrap_count
);

    localparam logic [WIDTH-1:0]      BIN_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]      BIN_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]      BIN_MAX  = {WIDTH{1'b1}};
    localparam logic [WRAP_CNT_W-1:0] CNT_ZERO = {WRAP_CNT_W{1'b0}};
    localparam logic [WRAP_CNT_W-1:0] CNT_ONE  = {{(WRAP_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WRAP_CNT_W-1:0] CNT_MAX  = {WRAP_CNT_W{1'b1}};

    state_t                  state_r, state_s;
    logic [WIDTH-1:0]        binary_r, binary_s;
    logic                    locked_r, locked_s;
    logic                    wrap_r, wrap_s;
    logic                    error_r, error_s;
    logic [1:0]              err_code_r, err_code_s;
    logic [WRAP_CNT_W-1:0]   wrap_count_r, wrap_count_s;

    logic [WIDTH-1:0]        dec_s;
    logic [WIDTH-1:0]        inc_s;
    logic                    hold_s;
    logic                    up_s;
    logic                    up_wrap_s;
    logic                    dn_s;
    logic                    dn_wrap_s;
    logic                    step_ok_s;
    logic                    ovf_exp_s;

    gray2bin #(
        .WIDTH (WIDTH)
    ) u_gray2bin (
        .gray (gray_in),
        .bin  (dec_s)
    );

    // Step classification of the new sample against the previous decode.
    // The +1 compare wraps naturally at WIDTH bits, so max -> 0 is an up step.
    assign inc_s     = binary_r + BIN_ONE;
    assign hold_s    = (dec_s == binary_r);
    assign up_s      = (dec_s == inc_s);
    assign up_wrap_s = up_s && (binary_r == BIN_MAX);

`ifdef GRAY_DOWN_STEP_EN
    logic [WIDTH-1:0] dec_minus_s;
    assign dec_minus_s = binary_r - BIN_ONE;
    assign dn_s        = (dec_s == dec_minus_s);
    assign dn_wrap_s   = dn_s && (binary_r == BIN_ZERO);
`else
    assign dn_s        = 1'b0;
    assign dn_wrap_s   = 1'b0;
`endif

    assign step_ok_s = hold_s || up_s || dn_s;

    // Overflow marks the terminal count in the direction of travel: max when
    // counting up or holding, zero after a down step.
    assign ovf_exp_s = dn_s ? (dec_s == BIN_ZERO) : (dec_s == BIN_MAX);

    // Next-state and next-output logic for the checker FSM.
    always_comb begin
        state_s      = state_r;
        binary_s     = binary_r;
        wrap_s       = 1'b0;
        error_s      = error_r;
        err_code_s   = err_code_r;
        wrap_count_s = wrap_count_r;

        if (clear) begin
            // Clear wins over a same-cycle sample; binary keeps its value.
            state_s      = ST_WAIT_FIRST;
            error_s      = 1'b0;
            err_code_s   = ERR_NONE;
            wrap_count_s = CNT_ZERO;
        end else if (valid) begin
            binary_s = dec_s;
            case (state_r)
                ST_WAIT_FIRST: begin
                    state_s = ST_TRACK;
                end
                ST_TRACK: begin
                    if (!step_ok_s) begin
                        state_s    = ST_FAULT;
                        error_s    = 1'b1;
                        err_code_s = ERR_STEP;
                    end else if (ovf_in != ovf_exp_s) begin
                        state_s    = ST_FAULT;
                        error_s    = 1'b1;
                        err_code_s = ERR_OVF;
                    end else if (up_wrap_s) begin
                        wrap_s = 1'b1;
                        if (wrap_count_r != CNT_MAX) begin
                            wrap_count_s = wrap_count_r + CNT_ONE;
                        end else begin
                            wrap_count_s = wrap_count_r;
                        end
                    end else if (dn_wrap_s) begin
                        wrap_s = 1'b1;
                    end else begin
                        wrap_s = 1'b0;
                    end
                end
                ST_FAULT: begin
                    state_s = ST_FAULT;
                end
                default: begin
                    // Unreachable encoding: fall back to a fresh reference.
                    state_s = ST_WAIT_FIRST;
                end
            endcase
        end else begin
            state_s = state_r;
        end

        locked_s = (state_s == ST_TRACK);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_WAIT_FIRST;
            binary_r     <= BIN_ZERO;
            locked_r     <= 1'b0;
            wrap_r       <= 1'b0;
            error_r      <= 1'b0;
            err_code_r   <= ERR_NONE;
            wrap_count_r <= CNT_ZERO;
        end else begin
            state_r      <= state_s;
            binary_r     <= binary_s;
            locked_r     <= locked_s;
            wrap_r       <= wrap_s;
            error_r      <= error_s;
            err_code_r   <= err_code_s;
            wrap_count_r <= wrap_count_s;
        end
    end

    assign binary     = binary_r;
    assign locked     = locked_r;
    assign wrap       = wrap_r;
    assign error      = error_r;
    assign err_code   = err_code_r;
    assign wrap_count = wrap_count_r;

endmodule

// File: tb/tb_gray_seq_checker.sv
// -----------------------------------------------------------------------------
// tb_gray_seq_checker
// Self-checking bench for gray_seq_checker (WIDTH=3, WRAP_CNT_W=8). Each
// driven sample updates a behavioural model whose expected outputs are queued
// and compared one cycle later against the DUT.
// -----------------------------------------------------------------------------
module tb_gray_seq_checker;

    logic       clk;
    logic       reset;
    logic       valid;
    logic [2:0] gray_in;
    logic       ovf_in;
    logic       clear;
    logic [2:0] binary;
    logic       locked;
    logic       wrap;
    logic       error;
    logic [1:0] err_code;
    logic [7:0] wrap_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int bin;
        int locked;
        int wrap;
        int err;
        int code;
        int cnt;
    } exp_t;

    exp_t sb_q[$];

    // Model state
    int m_state = 0;
    int m_bin   = 0;
    int m_wrap  = 0;
    int m_err   = 0;
    int m_code  = 0;
    int m_cnt   = 0;
`ifdef GRAY_DOWN_STEP_EN
    bit m_down  = 1'b1;
`else
    bit m_down  = 1'b0;
`endif

    gray_seq_checker #(
        .WIDTH      (3),
        .WRAP_CNT_W (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid),
        .gray_in    (gray_in),
        .ovf_in     (ovf_in),
        .clear      (clear),
        .binary     (binary),
        .locked     (locked),
        .wrap       (wrap),
        .error      (error),
        .err_code   (err_code),
        .wrap_count (wrap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int g2b(input int g);
        int b = 0;
        for (int s = 0; s < 3; s++) b = b ^ (g >> s);
        return b & 7;
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & 7;
    endfunction

    task automatic model_reset();
        m_state = 0; m_bin = 0; m_wrap = 0; m_err = 0; m_code = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit v, input int g, input bit o, input bit c);
        int  nb;
        int  d;
        bit  up;
        bit  dn;
        bit  oexp;
        exp_t e;
        if (c) begin
            m_state = 0; m_err = 0; m_code = 0; m_cnt = 0; m_wrap = 0;
        end else if (v) begin
            nb     = g2b(g);
            m_wrap = 0;
            if (m_state == 0) begin
                m_state = 1;
            end else if (m_state == 1) begin
                d    = (nb - m_bin + 8) % 8;
                up   = (d == 1);
                dn   = m_down && (d == 7);
                oexp = dn ? (nb == 0) : (nb == 7);
                if (!(d == 0 || up || dn)) begin
                    m_state = 2; m_err = 1; m_code = 1;
                end else if (o != oexp) begin
                    m_state = 2; m_err = 1; m_code = 2;
                end else if (up && m_bin == 7) begin
                    m_wrap = 1;
                    if (m_cnt < 255) m_cnt++;
                end else if (dn && m_bin == 0) begin
                    m_wrap = 1;
                end
            end
            m_bin = nb;
        end else begin
            m_wrap = 0;
        end
        e.bin = m_bin; e.locked = (m_state == 1); e.wrap = m_wrap;
        e.err = m_err; e.code = m_code; e.cnt = m_cnt;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of stimulus, then compare the DUT against the scoreboard.
    task automatic drive(input bit v, input logic [2:0] g, input bit o, input bit c);
        exp_t e;
        valid   = v;
        gray_in = g;
        ovf_in  = o;
        clear   = c;
        model_step(v, int'(g), o, c);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("binary",     32'(binary),     32'(e.bin));
        check("locked",     32'(locked),     32'(e.locked));
        check("wrap",       32'(wrap),       32'(e.wrap));
        check("error",      32'(error),      32'(e.err));
        check("err_code",   32'(err_code),   32'(e.code));
        check("wrap_count", 32'(wrap_count), 32'(e.cnt));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_binary"}, 32'(binary),     32'd0);
        check({tag, "_locked"}, 32'(locked),     32'd0);
        check({tag, "_wrap"},   32'(wrap),       32'd0);
        check({tag, "_error"},  32'(error),      32'd0);
        check({tag, "_code"},   32'(err_code),   32'd0);
        check({tag, "_count"},  32'(wrap_count), 32'd0);
    endtask

    initial begin
        int b;
        int r;
        logic [2:0] seq1 [9];
        logic [2:0] seq_dn [5];
        seq1   = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        seq_dn = '{3'b010, 3'b011, 3'b001, 3'b000, 3'b100};

        reset = 1'b1; valid = 1'b0; gray_in = 3'b000; ovf_in = 1'b0; clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_cleared("rst");
        @(negedge clk);
        reset = 1'b0;

        // Full up sequence with one wrap
        foreach (seq1[i]) drive(1'b1, seq1[i], (seq1[i] == 3'b100), 1'b0);
        drive(1'b0, 3'b000, 1'b0, 1'b0);

        // Illegal multi-step, then a later sample in FAULT
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        drive(1'b1, 3'b001, 1'b0, 1'b0);
        drive(1'b1, 3'b010, 1'b0, 1'b0);
        drive(1'b1, 3'b110, 1'b0, 1'b0);

        // Overflow mismatch at max, then clear with a simultaneous sample
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        drive(1'b1, 3'b101, 1'b0, 1'b0);
        drive(1'b1, 3'b100, 1'b0, 1'b0);
        drive(1'b1, 3'b000, 1'b0, 1'b1);

        // Repeated code: hold
        repeat (3) drive(1'b1, 3'b011, 1'b0, 1'b0);

        // Five full cycles, then asynchronous reset mid-count at 110
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        for (int k = 0; k <= 44; k++) begin
            drive(1'b1, 3'(b2g(k % 8)), ((k % 8) == 7), 1'b0);
        end
        #2;
        reset = 1'b1;
        #1;
        check_cleared("midrst");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 3'b111, 1'b0, 1'b0);
        drive(1'b1, 3'b111, 1'b0, 1'b0);

        // Down steps: legal only with the optional build
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        foreach (seq_dn[i]) drive(1'b1, seq_dn[i], (seq_dn[i] == 3'b000), 1'b0);
        drive(1'b0, 3'b000, 1'b0, 1'b0);

        // Wrap counter saturation
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        for (int k = 0; k < 258 * 8 + 1; k++) begin
            drive(1'b1, 3'(b2g(k % 8)), ((k % 8) == 7), 1'b0);
        end

        // Mixed random traffic with occasional idles and faults
        b = 0;
        for (int n = 0; n < 300; n++) begin
            if ((n % 60) == 0) begin
                drive(1'b0, 3'b000, 1'b0, 1'b1);
            end
            r = int'($urandom_range(0, 15));
            if (r == 0) begin
                drive(1'b0, 3'(b2g(b)), 1'b0, 1'b0);
            end else begin
                if (r < 4) b = b;
                else if (r < 14) b = (b + 1) % 8;
                else b = int'($urandom_range(0, 7));
                drive(1'b1, 3'(b2g(b)), ((b == 7) ^ (r == 15)), 1'b0);
            end
        end

        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
